alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Front-end and result stage for the 4-bit logic/arithmetic units (e.g. the AND unit with Z/N/C/V flags).
- Captures operand A then operand B from board switches on successive ENTER presses and drives them to the ALU.
- Waits a programmable settle time, then registers the ALU result and flags for the display/LED logic.
- Sits between the debounced board inputs and the ALU datapath/display drivers.

Parameters:
- WIDTH, 4, operand/result width in bits.
- SETTLE_CYCLES, 2, cycles spent in EXEC before result capture; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  WIDTH  switch value to capture as an operand.
- enter  in  1  debounced ENTER button, level; the block does its own edge detection.
- clear  in  1  synchronous clear, level, active-high.
- alu_r  in  WIDTH  ALU result, combinational from op_a/op_b.
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags.
- op_a  out  WIDTH  registered operand A to the ALU.
- op_b  out  WIDTH  registered operand B to the ALU.
- result  out  WIDTH  captured ALU result.
- flags  out  4  captured flags, packed {Z,N,C,V}.
- valid  out  1  result/flags hold a completed operation.
- busy  out  1  high while in EXEC.
- state  out  2  current state, for LEDs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=S_A, and op_a, op_b, result, flags, valid, counter all 0.
  - The edge-detect register enter_q resets to 1, so a button held through reset does not trigger.
- Edge detect:
  - press = enter & ~enter_q.
  - enter_q <= enter every cycle, including during clear.
  - One press per rising edge; holding the button produces a single press.
- State encoding: S_A=00, S_B=01, S_EXEC=10, S_SHOW=11. busy = (state==S_EXEC). All outputs are registered except busy and state decode.
- S_A: on press, op_a <= data_in and go to S_B. Otherwise hold.
- S_B: on press, op_b <= data_in, counter <= 0, and go to S_EXEC.
- S_EXEC:
  - counter increments each cycle; press is ignored; op_a/op_b are held stable.
  - In the cycle where counter == SETTLE_CYCLES-1:
    - result <= alu_r and flags <= {alu_z,alu_n,alu_c,alu_v}.
    - valid <= 1, go to S_SHOW.
  - With SETTLE_CYCLES=1, capture happens in the first EXEC cycle.
- Latency: if the B press is sampled at edge k, capture and valid rise occur at edge k+SETTLE_CYCLES.
- S_SHOW:
  - result, flags and valid are held; op_a/op_b are unchanged.
  - On press: op_a <= data_in, valid <= 0, go to S_B. This starts the next operation directly with A captured; result/flags keep their old values until the next capture.
- clear (synchronous):
  - Returns to S_A and zeroes op_a, op_b, result, flags, valid and counter.
  - Highest priority: clear together with press means clear wins and the press is discarded.
  - Clear in S_EXEC aborts with no capture.
- Reset mid-operation: immediate return to reset values regardless of state.
- Counter is 4 bits and never wraps (leaves EXEC at SETTLE_CYCLES-1).
- data_in is sampled only on press edges; changes at other times have no effect.

Test Plan:
- Reset with enter held high, then release rst_n → no capture; state=00 until enter drops and rises again.
- data_in=1100 press, data_in=1010 press, SETTLE_CYCLES=2 → op_a=1100, op_b=1010; busy for 2 cycles; then result=1000, flags=0100, valid=1 exactly 2 edges after the B press; state=11.
- A=0101, B=1010 → result=0000, flags=1000 (Z=1, N=0, C=V=0).
- Enter held high for 10 cycles in S_A → single capture, state=01 only. Extra presses during EXEC → ignored, capture timing unchanged.
- From S_SHOW with result=1000, press with data_in=0011 → valid=0, op_a=0011, state=01, result still 1000. Then B=0001 → result=0001, flags=0000.
- clear asserted in the same cycle as the B press, and separately clear during EXEC → state=00, all outputs 0, no capture. Async rst_n pulse mid-EXEC → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand capture / settle / result-capture sequencer sitting between the
// debounced board inputs and a small ALU plus its display logic.
module alu_operand_sequencer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enter,
  input  logic             clear,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EXEC = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             enter_q;
  logic             press_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_d, op_b_d, result_d;
  logic [3:0]       flags_d;
  logic             valid_d;

  // enter_q resets high so a button held through reset is not seen as a press
  assign press_c = enter & ~enter_q;
  assign state   = state_q;
  assign busy    = (state_q == S_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      enter_q <= 1'b1;
      cnt_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      flags   <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter;
      cnt_q   <= cnt_d;
      op_a    <= op_a_d;
      op_b    <= op_b_d;
      result  <= result_d;
      flags   <= flags_d;
      valid   <= valid_d;
    end
  end

  // Next-state and next-output logic; clear overrides everything, including a press
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a;
    op_b_d   = op_b;
    result_d = result;
    flags_d  = flags;
    valid_d  = valid;

    if (clear) begin
      state_d  = S_A;
      cnt_d    = '0;
      op_a_d   = '0;
      op_b_d   = '0;
      result_d = '0;
      flags_d  = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (press_c) begin
            op_a_d  = data_in;
            state_d = S_B;
          end
        end
        S_B: begin
          if (press_c) begin
            op_b_d  = data_in;
            cnt_d   = '0;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          // Counter stops advancing once EXEC is left, so it never wraps
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            result_d = alu_r;
            flags_d  = {alu_z, alu_n, alu_c, alu_v};
            valid_d  = 1'b1;
            state_d  = S_SHOW;
          end
        end
        S_SHOW: begin
          // A press here is operand A of the next operation
          if (press_c) begin
            op_a_d  = data_in;
            valid_d = 1'b0;
            state_d = S_B;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized and directed bench for alu_operand_sequencer against a
// cycle-level behavioural model driven by an AND-unit ALU stub.
module tb_alu_operand_sequencer;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SETTLE = 2;
  localparam int PH_A = 0, PH_B = 1, PH_EXEC = 2, PH_SHOW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             enter = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] alu_r;
  logic             alu_z, alu_n, alu_c, alu_v;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [3:0]       flags;
  logic             valid, busy;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;
  bit xflags = 1'b0;

  // Model state: phase, operands, captured values, cycles left before capture
  int         m_phase;
  logic [3:0] m_op_a, m_op_b, m_result, m_flags;
  bit         m_valid;
  bit         m_enter_q;
  int         m_left;

  alu_operand_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .enter(enter), .clear(clear),
    .alu_r(alu_r), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .op_a(op_a), .op_b(op_b), .result(result), .flags(flags),
    .valid(valid), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // AND-unit stub; with xf set, C and V carry arbitrary operand functions so
  // flag ordering is exercised too
  function automatic logic [3:0] alu_res(input logic [3:0] a, input logic [3:0] b);
    return a & b;
  endfunction

  function automatic logic [3:0] alu_flg(input logic [3:0] a, input logic [3:0] b, input bit xf);
    logic [3:0] r;
    r = a & b;
    return {r == 4'd0, r[3], xf & (a[0] ^ b[0]), xf & a[3] & ~b[3]};
  endfunction

  always_comb begin
    alu_r = alu_res(op_a, op_b);
    {alu_z, alu_n, alu_c, alu_v} = alu_flg(op_a, op_b, xflags);
  end

  function automatic void model_reset();
    m_phase = PH_A; m_op_a = '0; m_op_b = '0; m_result = '0; m_flags = '0;
    m_valid = 1'b0; m_enter_q = 1'b1; m_left = 0;
  endfunction

  function automatic void model_step(input bit en, input bit clr, input logic [3:0] d);
    bit press;
    press = en && !m_enter_q;
    m_enter_q = en;
    if (clr) begin
      model_reset();
      m_enter_q = en;
    end else if (m_phase == PH_A) begin
      if (press) begin m_op_a = d; m_phase = PH_B; end
    end else if (m_phase == PH_B) begin
      if (press) begin m_op_b = d; m_left = SETTLE; m_phase = PH_EXEC; end
    end else if (m_phase == PH_EXEC) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_result = alu_res(m_op_a, m_op_b);
        m_flags  = alu_flg(m_op_a, m_op_b, xflags);
        m_valid  = 1'b1;
        m_phase  = PH_SHOW;
      end
    end else if (press) begin
      m_op_a = d; m_valid = 1'b0; m_phase = PH_B;
    end
  endfunction

  function automatic logic [19:0] exp_vec();
    return {2'(m_phase), m_op_a, m_op_b, m_result, m_flags, m_valid, m_phase == PH_EXEC};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {state, op_a, op_b, result, flags, valid, busy};
  endfunction

  task automatic cycle(input bit en, input bit clr, input logic [3:0] d);
    enter = en; clear = clr; data_in = d;
    model_step(en, clr, d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    enter = 1'b1; clear = 1'b0; data_in = 4'hF;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 20'd0) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dut_vec(), 20'd0);
    end
    rst_n = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 4'hF);
    checks++;
    if (state !== 2'b00 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_held_enter: got %h expected %h", dut_vec(), exp_vec());
    end
    cycle(1'b0, 1'b0, 4'hF);
    cycle(1'b1, 1'b0, 4'b1100);
    checks++;
    if (state !== 2'b01 || op_a !== 4'b1100) begin
      errors++; $display("FAIL reset_first_press: got state %b op_a %b expected 01 1100", state, op_a);
    end
  endtask

  task automatic test_basic();
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'b1010);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0 || op_b !== 4'b1010 || state !== 2'b10) begin
      errors++; $display("FAIL basic_exec1: got busy %b valid %b op_b %b state %b expected 1 0 1010 10", busy, valid, op_b, state);
    end
    cycle(1'b1, 1'b0, 4'h0);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL basic_exec2: got busy %b valid %b expected 1 0", busy, valid);
    end
    cycle(1'b1, 1'b0, 4'h0);
    checks++;
    if (result !== 4'b1000 || flags !== 4'b0100 || valid !== 1'b1 || state !== 2'b11 || busy !== 1'b0
        || op_a !== 4'b1100) begin
      errors++; $display("FAIL basic_capture: got r %b f %b v %b st %b busy %b expected 1000 0100 1 11 0", result, flags, valid, state, busy);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL basic_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_show_restart();
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'b0011);
    checks++;
    if (valid !== 1'b0 || op_a !== 4'b0011 || state !== 2'b01 || result !== 4'b1000) begin
      errors++; $display("FAIL show_restart: got v %b op_a %b st %b r %b expected 0 0011 01 1000", valid, op_a, state, result);
    end
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'b0001);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    checks++;
    if (result !== 4'b0001 || flags !== 4'b0000 || valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL show_second_op: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_zero_flag();
    cycle(1'b1, 1'b0, 4'b0101);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'b1010);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    checks++;
    if (result !== 4'b0000 || flags !== 4'b1000 || valid !== 1'b1) begin
      errors++; $display("FAIL zero_flag: got r %b f %b v %b expected 0000 1000 1", result, flags, valid);
    end
  endtask

  task automatic test_hold_and_ignore();
    cycle(1'b0, 1'b1, 4'h0);
    checks++;
    if (dut_vec() !== 20'd0) begin
      errors++; $display("FAIL clear_from_show: got %h expected %h", dut_vec(), 20'd0);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, (i == 0) ? 4'h6 : 4'(i + 8));
    checks++;
    if (state !== 2'b01 || op_a !== 4'h6) begin
      errors++; $display("FAIL held_enter: got st %b op_a %h expected 01 6", state, op_a);
    end
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h7);
    cycle(1'b0, 1'b0, 4'h9);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL exec_mid: got v %b busy %b expected 0 1", valid, busy);
    end
    cycle(1'b1, 1'b0, 4'hE);
    checks++;
    if (valid !== 1'b1 || state !== 2'b11 || result !== 4'h6 || op_a !== 4'h6 || op_b !== 4'h7) begin
      errors++; $display("FAIL exec_press_ignored: got %h expected %h", dut_vec(), exp_vec());
    end
    cycle(1'b1, 1'b0, 4'hE);
    checks++;
    if (state !== 2'b11 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL show_hold: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clear();
    cycle(1'b0, 1'b1, 4'h0);
    cycle(1'b1, 1'b0, 4'h3);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b1, 4'h5);
    checks++;
    if (dut_vec() !== 20'd0) begin
      errors++; $display("FAIL clear_with_press: got %h expected %h", dut_vec(), 20'd0);
    end
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h3);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h5);
    cycle(1'b0, 1'b1, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    checks++;
    if (dut_vec() !== 20'd0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL clear_in_exec: got %h expected %h", dut_vec(), 20'd0);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h9);
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'hB);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 20'd0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 20'd0);
    end
    @(posedge clk); #1;
    enter = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL after_async_reset: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit en, clr;
    xflags = 1'b1;
    for (int i = 0; i < 500; i++) begin
      en  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 39) == 0);
      cycle(en, clr, 4'($urandom_range(0, 15)));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_show_restart();
    test_zero_flag();
    test_hold_and_ignore();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
